// File: rtl/sum_result_framer_if.sv
// Port bundle for sum_result_framer: MAC sum strobe in, framed byte stream out.
// The framer side uses master; the driving/consuming environment uses slave.
interface sum_result_framer_if #(
   parameter int unsigned SUM_W = 21
);
   logic [SUM_W-1:0] sum_in;
   logic             sum_valid;
   logic             out_ready;
   logic [7:0]       data_out;
   logic             out_valid;
   logic             frame_start;
   logic             detect;

   modport master (
      input  sum_in, sum_valid, out_ready,
      output data_out, out_valid, frame_start, detect
   );

   modport slave (
      output sum_in, sum_valid, out_ready,
      input  data_out, out_valid, frame_start, detect
   );
endinterface

// File: rtl/sum_result_framer.sv
// Hysteresis threshold detector on each 21-bit MAC sum, plus a 4-byte
// serializer (sync, flags+sum[20:16], sum[15:8], sum[7:0]) on a valid/ready byte stream.
module sum_result_framer #(
   parameter int unsigned      SUM_W     = 21,
   parameter logic [SUM_W-1:0] THR_ON    = 21'd1000,
   parameter logic [SUM_W-1:0] THR_OFF   = 21'd600,
   parameter int unsigned      CONFIRM_N = 3,
   parameter logic [7:0]       SYNC_BYTE = 8'hA5
) (
   input logic                 clk,
   input logic                 rst_n,
   sum_result_framer_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_B0,
      S_B1,
      S_B2,
      S_B3
   } state_t;

   localparam logic [2:0] CONFIRM = 3'(CONFIRM_N);

   state_t           state_q, state_d;
   logic [2:0]       run_cnt_q, run_cnt_d;
   logic             detect_q, detect_d;
   logic             drop_q, drop_d;
   logic [SUM_W-1:0] sum_sh_q, sum_sh_d;
   logic             det_sh_q, det_sh_d;
   logic             drop_sh_q, drop_sh_d;
   logic [7:0]       data_q, data_d;
   logic             fs_q, fs_d;
   logic             hs;
   logic             accept;

   // Detector runs on every strobe, independent of framer occupancy.
   always_comb begin
      run_cnt_d = run_cnt_q;
      detect_d  = detect_q;
      if (bus.sum_valid) begin
         if (bus.sum_in >= THR_ON) begin
            if (run_cnt_q != CONFIRM) run_cnt_d = run_cnt_q + 3'd1;
            if (run_cnt_d == CONFIRM) detect_d = 1'b1;
         end else begin
            run_cnt_d = '0;
            if (bus.sum_in < THR_OFF) detect_d = 1'b0;
         end
      end
   end

   assign hs     = (state_q != S_IDLE) && bus.out_ready;
   assign accept = bus.sum_valid && ((state_q == S_IDLE) || ((state_q == S_B3) && hs));

   always_comb begin
      state_d   = state_q;
      drop_d    = drop_q;
      sum_sh_d  = sum_sh_q;
      det_sh_d  = det_sh_q;
      drop_sh_d = drop_sh_q;
      data_d    = data_q;
      fs_d      = 1'b0;
      if (accept) begin
         // Shadow the post-update detect so the frame reports this sample's decision.
         sum_sh_d  = bus.sum_in;
         det_sh_d  = detect_d;
         drop_sh_d = drop_q;
         drop_d    = 1'b0;
         state_d   = S_B0;
         data_d    = SYNC_BYTE;
         fs_d      = 1'b1;
      end else begin
         if (bus.sum_valid) drop_d = 1'b1;
         if (hs) begin
            case (state_q)
               S_B0: begin
                  state_d = S_B1;
                  data_d  = {det_sh_q, drop_sh_q, 1'b0, sum_sh_q[20:16]};
               end
               S_B1: begin
                  state_d = S_B2;
                  data_d  = sum_sh_q[15:8];
               end
               S_B2: begin
                  state_d = S_B3;
                  data_d  = sum_sh_q[7:0];
               end
               S_B3: begin
                  state_d = S_IDLE;
                  data_d  = '0;
               end
               default: begin
                  state_d = S_IDLE;
                  data_d  = '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         run_cnt_q <= '0;
         detect_q  <= 1'b0;
         drop_q    <= 1'b0;
         sum_sh_q  <= '0;
         det_sh_q  <= 1'b0;
         drop_sh_q <= 1'b0;
         data_q    <= '0;
         fs_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         run_cnt_q <= run_cnt_d;
         detect_q  <= detect_d;
         drop_q    <= drop_d;
         sum_sh_q  <= sum_sh_d;
         det_sh_q  <= det_sh_d;
         drop_sh_q <= drop_sh_d;
         data_q    <= data_d;
         fs_q      <= fs_d;
      end
   end

   assign bus.out_valid   = (state_q != S_IDLE);
   assign bus.data_out    = data_q;
   assign bus.frame_start = fs_q;
   assign bus.detect      = detect_q;

endmodule

// File: tb/tb_sum_result_framer.sv
// Directed bench for sum_result_framer: frame layout, stalls, hysteresis,
// drop flag, back-to-back framing and asynchronous reset abort.
module tb_sum_result_framer;
   logic        clk = 1'b0;
   logic        rst_n;
   int unsigned checks = 0;
   int unsigned fails  = 0;
   logic [7:0]  stall_b [8];
   logic        stall_r [8];

   sum_result_framer_if #(.SUM_W(21)) bus ();

   sum_result_framer #(
      .SUM_W(21),
      .THR_ON(21'd1000),
      .THR_OFF(21'd600),
      .CONFIRM_N(3),
      .SYNC_BYTE(8'hA5)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic get_byte(input string tag, input logic [7:0] exp_data, input logic exp_fs);
      int unsigned n = 0;
      while (bus.out_valid !== 1'b1 && n < 16) begin
         tick();
         n++;
      end
      chk({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
      chk(tag, {24'b0, bus.data_out}, {24'b0, exp_data});
      chk({tag, "_fs"}, {31'b0, bus.frame_start}, {31'b0, exp_fs});
      tick();
   endtask

   task automatic send(input logic [20:0] v);
      bus.sum_in    = v;
      bus.sum_valid = 1'b1;
      tick();
      bus.sum_valid = 1'b0;
   endtask

   task automatic frame(input string tag, input logic [20:0] v, input logic [7:0] b1, input logic det);
      send(v);
      chk({tag, "_det"}, {31'b0, bus.detect}, {31'b0, det});
      get_byte({tag, "_b0"}, 8'hA5, 1'b1);
      get_byte({tag, "_b1"}, b1, 1'b0);
      get_byte({tag, "_b2"}, v[15:8], 1'b0);
      get_byte({tag, "_b3"}, v[7:0], 1'b0);
      chk({tag, "_idle"}, {31'b0, bus.out_valid}, 32'd0);
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      bus.sum_valid = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.sum_in    = '0;
      bus.sum_valid = 1'b0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("rst_data", {24'b0, bus.data_out}, 32'd0);
      chk("rst_fs", {31'b0, bus.frame_start}, 32'd0);
      chk("rst_det", {31'b0, bus.detect}, 32'd0);
      rst_n = 1'b1;
      tick();
      bus.out_ready = 1'b1;

      frame("single", 21'h1ABCD, 8'h01, 1'b0);

      // Stalled consumer: each byte must hold until its handshake.
      stall_b = '{8'hA5, 8'h01, 8'h01, 8'h01, 8'hAB, 8'hAB, 8'hCD, 8'hCD};
      stall_r = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      send(21'h1ABCD);
      for (int i = 0; i < 8; i++) begin
         chk("stall_valid", {31'b0, bus.out_valid}, 32'd1);
         chk("stall_byte", {24'b0, bus.data_out}, {24'b0, stall_b[i]});
         chk("stall_fs", {31'b0, bus.frame_start}, {31'b0, (i == 0)});
         bus.out_ready = stall_r[i];
         tick();
      end
      chk("stall_idle", {31'b0, bus.out_valid}, 32'd0);
      bus.out_ready = 1'b1;

      do_reset();
      frame("d1200", 21'd1200, 8'h00, 1'b0);
      frame("d1500", 21'd1500, 8'h00, 1'b0);
      frame("d1100", 21'd1100, 8'h80, 1'b1);
      frame("d800", 21'd800, 8'h80, 1'b1);
      frame("d500", 21'd500, 8'h00, 1'b0);
      frame("d1200a", 21'd1200, 8'h00, 1'b0);
      frame("d1200b", 21'd1200, 8'h00, 1'b0);

      do_reset();
      frame("e1000a", 21'd1000, 8'h00, 1'b0);
      frame("e1000b", 21'd1000, 8'h00, 1'b0);
      frame("e1000c", 21'd1000, 8'h80, 1'b1);
      frame("e600", 21'd600, 8'h80, 1'b1);
      frame("e599", 21'd599, 8'h00, 1'b0);

      // Second sample arrives while sum 50 is in B1 and must be dropped.
      send(21'd50);
      get_byte("dr_b0", 8'hA5, 1'b1);
      chk("dr_b1", {24'b0, bus.data_out}, 32'h00);
      bus.sum_in    = 21'd60;
      bus.sum_valid = 1'b1;
      tick();
      bus.sum_valid = 1'b0;
      get_byte("dr_b2", 8'h00, 1'b0);
      get_byte("dr_b3", 8'h32, 1'b0);
      chk("dr_idle", {31'b0, bus.out_valid}, 32'd0);
      frame("dr70", 21'd70, 8'h40, 1'b0);
      frame("dr80", 21'd80, 8'h00, 1'b0);

      // Back-to-back: next sum strobed during the B3 handshake.
      send(21'h000123);
      get_byte("bb_b0", 8'hA5, 1'b1);
      get_byte("bb_b1", 8'h00, 1'b0);
      get_byte("bb_b2", 8'h01, 1'b0);
      chk("bb_b3", {24'b0, bus.data_out}, 32'h23);
      bus.sum_in    = 21'h1FFFFF;
      bus.sum_valid = 1'b1;
      tick();
      bus.sum_valid = 1'b0;
      chk("bb_nobubble", {31'b0, bus.out_valid}, 32'd1);
      chk("bb_det", {31'b0, bus.detect}, 32'd0);
      get_byte("bb2_b0", 8'hA5, 1'b1);
      get_byte("bb2_b1", 8'h1F, 1'b0);
      get_byte("bb2_b2", 8'hFF, 1'b0);
      get_byte("bb2_b3", 8'hFF, 1'b0);
      chk("bb2_idle", {31'b0, bus.out_valid}, 32'd0);

      // Asynchronous reset during B2 of a detected frame.
      do_reset();
      frame("r1", 21'd2000, 8'h00, 1'b0);
      frame("r2", 21'd2000, 8'h00, 1'b0);
      frame("r3", 21'd2000, 8'h80, 1'b1);
      send(21'd2000);
      get_byte("r4_b0", 8'hA5, 1'b1);
      get_byte("r4_b1", 8'h80, 1'b0);
      chk("r4_b2", {24'b0, bus.data_out}, 32'h07);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("ar_data", {24'b0, bus.data_out}, 32'd0);
      chk("ar_fs", {31'b0, bus.frame_start}, 32'd0);
      chk("ar_det", {31'b0, bus.detect}, 32'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("ar_quiet", {31'b0, bus.out_valid}, 32'd0);
      end
      frame("post", 21'd1200, 8'h00, 1'b0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
